stopwatch_counter: RTL and testbench

Stopwatch timebase and digit-counter block for the stopwatch datapath: divides the system clock to a 10 Hz tenths tick and holds four BCD digit registers (M:SS.t). On each tick it advances the digits through the 4-bit incrementer stage, one stage per digit, with its Cin driven by the carry chain. The block owns the per-digit wrap limits, the run/stop/clear state machine and lap-freeze display logic, and feeds the seven-segment display driver downstream.

---
 rtl/stopwatch_counter.sv | 199 +++++++++++++++++++
 tb/tb_stopwatch_counter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_counter.sv
// stopwatch_counter
// Timebase and M:SS.t digit counter for the stopwatch datapath.
// A prescaler divides clk down to a tenth-second tick. On each tick a chain
// of four BCD incrementers advances the time. A small run/stop/clear state
// machine gates the counting, and a lap register set can freeze the display.
//
// Ports
//   clk         system clock, all state on rising edge
//   rst_n       asynchronous active-low reset
//   start_stop  single-cycle pulse, toggles run/stop
//   clear       single-cycle pulse, zeroes time when not running
//   lap         single-cycle pulse, toggles display freeze
//   disp_t      displayed tenths digit (BCD 0-9)
//   disp_su     displayed seconds-units digit (BCD 0-9)
//   disp_st     displayed seconds-tens digit (BCD 0-5)
//   disp_m      displayed minutes digit (BCD 0-9)
//   running     high while counting
//   lap_hold    high while the display is frozen on the lap registers
//   wrap        one-cycle pulse after 9:59.9 rolls over to 0:00.0
module stopwatch_counter #(
    parameter int CLK_DIV = 5_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       lap,
    output logic [3:0] disp_t,
    output logic [3:0] disp_su,
    output logic [3:0] disp_st,
    output logic [3:0] disp_m,
    output logic       running,
    output logic       lap_hold,
    output logic       wrap
);

    localparam int            PW        = $clog2(CLK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_STOP = 2'd2;

    localparam logic [3:0] LIM_T  = 4'd9;
    localparam logic [3:0] LIM_SU = 4'd9;
    localparam logic [3:0] LIM_ST = 4'd5;
    localparam logic [3:0] LIM_M  = 4'd9;

    logic [1:0]    state_q,   state_d;
    logic [PW-1:0] presc_q,   presc_d;
    logic [3:0]    tenths_q,  tenths_d;
    logic [3:0]    secUnit_q, secUnit_d;
    logic [3:0]    secTen_q,  secTen_d;
    logic [3:0]    minute_q,  minute_d;
    logic [3:0]    lapT_q,    lapT_d;
    logic [3:0]    lapSu_q,   lapSu_d;
    logic [3:0]    lapSt_q,   lapSt_d;
    logic [3:0]    lapM_q,    lapM_d;
    logic          lapHold_q, lapHold_d;
    logic          wrap_q,    wrap_d;

    logic          tick;
    logic          cinSu, cinSt, cinM, rollover;
    logic [3:0]    incT, incSu, incSt, incM;

    // One BCD incrementer stage: a digit sitting at its limit goes to 0
    // instead of taking the binary sum.
    function automatic logic [3:0] incDigit(input logic [3:0] d,
                                            input logic       cin,
                                            input logic [3:0] lim);
        if (!cin)
            return d;
        else if (d == lim)
            return 4'd0;
        else
            return d + 4'd1;
    endfunction

    assign tick = (state_q == ST_RUN) && (presc_q == PRESC_MAX);

    // Ripple carry: a digit advances only when every lower digit is at its limit.
    assign cinSu    = tick  && (tenths_q  == LIM_T);
    assign cinSt    = cinSu && (secUnit_q == LIM_SU);
    assign cinM     = cinSt && (secTen_q  == LIM_ST);
    assign rollover = cinM  && (minute_q  == LIM_M);

    assign incT  = incDigit(tenths_q,  tick,  LIM_T);
    assign incSu = incDigit(secUnit_q, cinSu, LIM_SU);
    assign incSt = incDigit(secTen_q,  cinSt, LIM_ST);
    assign incM  = incDigit(minute_q,  cinM,  LIM_M);

    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        tenths_d  = tenths_q;
        secUnit_d = secUnit_q;
        secTen_d  = secTen_q;
        minute_d  = minute_q;
        lapT_d    = lapT_q;
        lapSu_d   = lapSu_q;
        lapSt_d   = lapSt_q;
        lapM_d    = lapM_q;
        lapHold_d = lapHold_q;
        wrap_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                presc_d = '0;
                if (!clear && start_stop)
                    state_d = ST_RUN;
            end

            ST_RUN: begin
                presc_d   = tick ? '0 : presc_q + 1'b1;
                tenths_d  = incT;
                secUnit_d = incSu;
                secTen_d  = incSt;
                minute_d  = incM;
                wrap_d    = rollover;
                if (start_stop)
                    state_d = ST_STOP;
                // Capturing the incremented values keeps the frozen time
                // consistent with what the live display would show this cycle.
                if (lap) begin
                    lapHold_d = !lapHold_q;
                    if (!lapHold_q) begin
                        lapT_d  = incT;
                        lapSu_d = incSu;
                        lapSt_d = incSt;
                        lapM_d  = incM;
                    end
                end
            end

            ST_STOP: begin
                // clear has priority over start_stop and lap here.
                if (clear) begin
                    state_d   = ST_IDLE;
                    presc_d   = '0;
                    tenths_d  = 4'd0;
                    secUnit_d = 4'd0;
                    secTen_d  = 4'd0;
                    minute_d  = 4'd0;
                    lapT_d    = 4'd0;
                    lapSu_d   = 4'd0;
                    lapSt_d   = 4'd0;
                    lapM_d    = 4'd0;
                    lapHold_d = 1'b0;
                end else begin
                    if (start_stop)
                        state_d = ST_RUN;
                    if (lap)
                        lapHold_d = 1'b0;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            presc_q   <= '0;
            tenths_q  <= 4'd0;
            secUnit_q <= 4'd0;
            secTen_q  <= 4'd0;
            minute_q  <= 4'd0;
            lapT_q    <= 4'd0;
            lapSu_q   <= 4'd0;
            lapSt_q   <= 4'd0;
            lapM_q    <= 4'd0;
            lapHold_q <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            tenths_q  <= tenths_d;
            secUnit_q <= secUnit_d;
            secTen_q  <= secTen_d;
            minute_q  <= minute_d;
            lapT_q    <= lapT_d;
            lapSu_q   <= lapSu_d;
            lapSt_q   <= lapSt_d;
            lapM_q    <= lapM_d;
            lapHold_q <= lapHold_d;
            wrap_q    <= wrap_d;
        end
    end

    assign disp_t   = lapHold_q ? lapT_q  : tenths_q;
    assign disp_su  = lapHold_q ? lapSu_q : secUnit_q;
    assign disp_st  = lapHold_q ? lapSt_q : secTen_q;
    assign disp_m   = lapHold_q ? lapM_q  : minute_q;
    assign running  = (state_q == ST_RUN);
    assign lap_hold = lapHold_q;
    assign wrap     = wrap_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// tb_stopwatch_counter
// Directed bench for stopwatch_counter with CLK_DIV = 4, so one tenth is
// four clocks. Inputs change 1 time unit after a rising edge and outputs are
// sampled at that same point. Expected display values are written as BCD
// hex M_S_S_t, e.g. 16'h0237 means 2:03.7.
module tb_stopwatch_counter;

    logic       clk;
    logic       rst_n;
    logic       start_stop;
    logic       clear;
    logic       lap;
    logic [3:0] disp_t, disp_su, disp_st, disp_m;
    logic       running, lap_hold, wrap;

    int checks = 0;
    int errors = 0;

    stopwatch_counter #(.CLK_DIV(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_stop (start_stop),
        .clear      (clear),
        .lap        (lap),
        .disp_t     (disp_t),
        .disp_su    (disp_su),
        .disp_st    (disp_st),
        .disp_m     (disp_m),
        .running    (running),
        .lap_hold   (lap_hold),
        .wrap       (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one set of pulses for exactly one rising edge.
    task automatic applyStimulus(input logic ss, input logic clr, input logic lp);
        start_stop = ss;
        clear      = clr;
        lap        = lp;
        @(posedge clk);
        #1;
        start_stop = 1'b0;
        clear      = 1'b0;
        lap        = 1'b0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] dispVal();
        return {16'h0, disp_m, disp_st, disp_su, disp_t};
    endfunction

    task automatic checkTime(input string tag, input logic [15:0] expTime,
                             input logic expRun, input logic expHold);
        checkOutput({tag, "_disp"}, dispVal(), {16'h0, expTime});
        checkOutput({tag, "_running"}, {31'h0, running}, {31'h0, expRun});
        checkOutput({tag, "_lap_hold"}, {31'h0, lap_hold}, {31'h0, expHold});
    endtask

    initial begin
        rst_n      = 1'b0;
        start_stop = 1'b0;
        clear      = 1'b0;
        lap        = 1'b0;
        #12;
        rst_n = 1'b1;
        waitCycles(1);

        // Reset state
        checkTime("reset", 16'h0000, 1'b0, 1'b0);
        checkOutput("reset_wrap", {31'h0, wrap}, 32'h0);

        // lap in IDLE is ignored
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkTime("idle_lap", 16'h0000, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a run at 0:03.7
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitCycles(148);
        checkTime("prereset", 16'h0037, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        checkTime("async_reset", 16'h0000, 1'b0, 1'b0);
        #2;
        rst_n = 1'b1;
        waitCycles(3);
        checkTime("post_reset_idle", 16'h0000, 1'b0, 1'b0);
        // Prescaler restarts from zero: first tick on the fourth edge after start
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitCycles(3);
        checkTime("presc_zero_a", 16'h0000, 1'b1, 1'b0);
        waitCycles(1);
        checkTime("presc_zero_b", 16'h0001, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkTime("back_to_idle", 16'h0000, 1'b0, 1'b0);

        // Basic count
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitCycles(40);
        checkTime("count_1_0", 16'h0010, 1'b1, 1'b0);
        waitCycles(236);
        checkTime("count_6_9", 16'h0069, 1'b1, 1'b0);
        waitCycles(4);
        checkTime("count_7_0", 16'h0070, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkTime("count_cleared", 16'h0000, 1'b0, 1'b0);

        // Pause / resume keeps the partial tenth
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitCycles(6);
        checkTime("pause_run", 16'h0001, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkTime("pause_stop", 16'h0001, 1'b0, 1'b0);
        waitCycles(100);
        checkTime("pause_idle100", 16'h0001, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitCycles(2);
        checkTime("resume", 16'h0002, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkTime("clear_in_run", 16'h0002, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkTime("stop_again", 16'h0002, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkTime("stop_clear", 16'h0000, 1'b0, 1'b0);

        // Lap freeze
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitCycles(100);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkTime("lap_set", 16'h0025, 1'b1, 1'b1);
        waitCycles(59);
        checkTime("lap_frozen", 16'h0025, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkTime("lap_release", 16'h0040, 1'b1, 1'b0);
        waitCycles(2);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkTime("lap_on_tick", 16'h0041, 1'b1, 1'b1);
        waitCycles(8);
        checkTime("lap_frozen2", 16'h0041, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkTime("lap_stop", 16'h0041, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkTime("lap_in_stop", 16'h0043, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkTime("lap_in_stop2", 16'h0043, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkTime("lap_cleared", 16'h0000, 1'b0, 1'b0);

        // Full wrap 9:59.9 -> 0:00.0
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitCycles(23996);
        checkTime("wrap_9599", 16'h9599, 1'b1, 1'b0);
        checkOutput("wrap_before", {31'h0, wrap}, 32'h0);
        waitCycles(3);
        checkOutput("wrap_early", {31'h0, wrap}, 32'h0);
        waitCycles(1);
        checkTime("wrap_zero", 16'h0000, 1'b1, 1'b0);
        checkOutput("wrap_pulse", {31'h0, wrap}, 32'h1);
        waitCycles(1);
        checkOutput("wrap_after", {31'h0, wrap}, 32'h0);
        checkOutput("wrap_running", {31'h0, running}, 32'h1);

        // start_stop + lap together in RUN
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkTime("ss_lap_run", 16'h0000, 1'b0, 1'b1);

        // clear + start_stop in STOP: clear wins
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkTime("clr_ss_stop", 16'h0000, 1'b0, 1'b0);
        waitCycles(5);
        checkTime("clr_ss_idle", 16'h0000, 1'b0, 1'b0);

        // tick coincident with start_stop: increment then STOP
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitCycles(3);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkTime("tick_stop", 16'h0001, 1'b0, 1'b0);
        waitCycles(10);
        checkTime("tick_stop_hold", 16'h0001, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
